vga_display_gen: RTL

VGA_DISPLAY_GEN -- requirements
Module: vga_display_gen

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_sync_counter.sv | 64 ++++++
 rtl/vga_display_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display generator: pattern mode encodings,
// default 640x480@60 timing and a small helper for computing line/frame totals.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_EXT   = 2'd3
  } vga_mode_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters with wrap logic and the region decodes
// (active area, sync windows, frame boundaries) derived from them.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          vga_clk,
  input  logic          rst_n,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hs_active,
  output logic          vs_active,
  output logic          line_last,
  output logic          frame_first,
  output logic          frame_last
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          v_last;

  assign line_last = (32'(h_q) == H_TOTAL - 1);
  assign v_last    = (32'(v_q) == V_TOTAL - 1);

  always_comb begin
    h_d = line_last ? '0 : h_q + HW'(1);
    v_d = v_q;
    if (line_last) begin
      v_d = v_last ? '0 : v_q + VW'(1);
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign active      = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
  assign hs_active   = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_active   = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);
  assign frame_first = (h_q == '0) && (v_q == '0);
  assign frame_last  = line_last && v_last;

endmodule

// File: rtl/vga_display_gen.sv
// VGA test-pattern generator: raster timing from vga_sync_counter, a pattern
// mux (solid, bars, checkerboard, external) and one stage of output registers.
module vga_display_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FP       = VGA_H_FP,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BP       = VGA_H_BP,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FP       = VGA_V_FP,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BP       = VGA_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_BITS = 1,
  parameter int CHK_LOG2   = 5,
  localparam int H_TOTAL   = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL   = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL),
  localparam int RGB_W     = 3 * COLOR_BITS
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [RGB_W-1:0] solid_rgb,
  input  logic [RGB_W-1:0] pixel_in,
  output logic [HW-1:0]    pix_x,
  output logic [VW-1:0]    pix_y,
  output logic             pix_req,
  output logic [RGB_W-1:0] RGB,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start
);

  // A zero-width bar would never advance, so very narrow rasters use width 1.
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BPW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active, hs_active, vs_active;
  logic          line_last, frame_first, frame_last;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hs_active   (hs_active),
    .vs_active   (vs_active),
    .line_last   (line_last),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  assign pix_x   = h_cnt;
  assign pix_y   = v_cnt;
  assign pix_req = active;

  vga_mode_e        mode_q, mode_d;
  logic [BPW-1:0]   bar_px_q, bar_px_d;
  logic [2:0]       bar_k_q, bar_k_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             de_q, de_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             fs_q, fs_d;
  logic [RGB_W-1:0] bar_rgb;
  logic [RGB_W-1:0] pat_rgb;
  logic             chk_on;

  // Mode only changes at the very last raster position so a frame never tears.
  assign mode_d = frame_last ? vga_mode_e'(mode) : mode_q;

  always_comb begin
    bar_px_d = bar_px_q;
    bar_k_d  = bar_k_q;
    if (line_last) begin
      bar_px_d = '0;
      bar_k_d  = '0;
    end else if (active) begin
      if (32'(bar_px_q) == BAR_W - 1) begin
        bar_px_d = '0;
        if (bar_k_q != 3'd7) begin
          bar_k_d = bar_k_q + 3'd1;
        end
      end else begin
        bar_px_d = bar_px_q + BPW'(1);
      end
    end
  end

  // Channel gi of {R,G,B} (B at gi=0) is lit by bit gi of the bar index.
  for (genvar gi = 0; gi < 3; gi++) begin : g_bar_chan
    assign bar_rgb[gi*COLOR_BITS +: COLOR_BITS] = {COLOR_BITS{bar_k_q[gi]}};
  end

  assign chk_on = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];

  always_comb begin
    pat_rgb = '0;
    case (mode_q)
      MODE_SOLID: pat_rgb = solid_rgb;
      MODE_BARS:  pat_rgb = bar_rgb;
      MODE_CHECK: pat_rgb = {RGB_W{chk_on}};
      MODE_EXT:   pat_rgb = pixel_in;
      default:    pat_rgb = '0;
    endcase
  end

  always_comb begin
    rgb_d   = active ? pat_rgb : '0;
    de_d    = active;
    hsync_d = hs_active ? HS_POL : ~HS_POL;
    vsync_d = vs_active ? VS_POL : ~VS_POL;
    fs_d    = frame_first;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_SOLID;
      bar_px_q <= '0;
      bar_k_q  <= '0;
      rgb_q    <= '0;
      de_q     <= 1'b0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      fs_q     <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      bar_px_q <= bar_px_d;
      bar_k_q  <= bar_k_d;
      rgb_q    <= rgb_d;
      de_q     <= de_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= fs_d;
    end
  end

  assign RGB         = rgb_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule
